// File: rtl/vectored_irq_controller.sv
// Vectored interrupt controller: NUM_IRQ edge/level request lines, enable mask,
// fixed lowest-index-wins priority, and a per-channel handler address.
// Ports: clk/RESET (async, active-high); IrqIn raw requests; MaskWE/MaskWD
// enable write; pc_31 supervisor suppress; IrqAck/Eoi core handshake;
// IRQ/InService decoded from state; VecAddr/ActiveId/Pending/Enable registered.
// Latency: a request sampled at clk k raises IRQ after clk k+1.
// Backpressure: a held IRQ waits for IrqAck; no new request is issued until Eoi.
module vectored_irq_controller #(
    parameter int                     NUM_IRQ    = 8,
    parameter int                     ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  VEC_BASE   = 32'h80000008,
    parameter int                     VEC_STRIDE = 4,
    parameter logic [NUM_IRQ-1:0]     EDGE_MASK  = {NUM_IRQ{1'b1}},
    localparam int                    ID_W       = $clog2(NUM_IRQ)
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [NUM_IRQ-1:0]    IrqIn,
    input  logic                  MaskWE,
    input  logic [NUM_IRQ-1:0]    MaskWD,
    input  logic                  pc_31,
    input  logic                  IrqAck,
    input  logic                  Eoi,
    output logic                  IRQ,
    output logic [ADDR_WIDTH-1:0] VecAddr,
    output logic [ID_W-1:0]       ActiveId,
    output logic                  InService,
    output logic [NUM_IRQ-1:0]    Pending,
    output logic [NUM_IRQ-1:0]    Enable
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_IRQ-1:0]      pending_q, pending_d;
    logic [NUM_IRQ-1:0]      enable_q, enable_d;
    logic [NUM_IRQ-1:0]      prev_q, prev_d;
    logic [ID_W-1:0]         active_id_q, active_id_d;
    logic [ADDR_WIDTH-1:0]   vec_addr_q, vec_addr_d;

    logic [NUM_IRQ-1:0]      cand;
    logic                    win_vld;
    logic [ID_W-1:0]         win_id;
    logic [NUM_IRQ-1:0]      ack_clr;
    logic [NUM_IRQ-1:0]      edge_set;

    // Priority search over registered state only, so a mask write or a new
    // edge influences arbitration one cycle after it is captured.
    always_comb begin
        cand    = pending_q & enable_q;
        win_vld = 1'b0;
        win_id  = '0;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        vec_addr_d  = vec_addr_q;
        ack_clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld && !pc_31) begin
                    state_d     = REQ;
                    active_id_d = win_id;
                    vec_addr_d  = VEC_BASE
                                + ADDR_WIDTH'(VEC_STRIDE) * ADDR_WIDTH'(win_id);
                end
            end
            REQ: begin
                // Withdraw the request if the winner became ineligible; the
                // channel stays pending and competes again from IDLE.
                if (pc_31 || !enable_q[active_id_q] || !pending_q[active_id_q]) begin
                    state_d = IDLE;
                end else if (IrqAck) begin
                    state_d              = SERVICE;
                    ack_clr[active_id_q] = 1'b1;
                end
            end
            SERVICE: begin
                if (Eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge channels: a fresh edge wins over a same-cycle acknowledge clear.
    // Level channels simply follow the line; acknowledge has no effect there.
    always_comb begin
        prev_d    = IrqIn;
        edge_set  = IrqIn & ~prev_q;
        pending_d = (EDGE_MASK & ((pending_q & ~ack_clr) | edge_set))
                  | (~EDGE_MASK & IrqIn);
        enable_d  = MaskWE ? MaskWD : enable_q;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            enable_q    <= '0;
            prev_q      <= '0;
            active_id_q <= '0;
            vec_addr_q  <= VEC_BASE;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            prev_q      <= prev_d;
            active_id_q <= active_id_d;
            vec_addr_q  <= vec_addr_d;
        end
    end

    assign IRQ       = (state_q == REQ);
    assign InService = (state_q == SERVICE);
    assign VecAddr   = vec_addr_q;
    assign ActiveId  = active_id_q;
    assign Pending   = pending_q;
    assign Enable    = enable_q;

endmodule

// File: tb/tb_vectored_irq_controller.sv
module tb_vectored_irq_controller;

    localparam int N = 8;

    logic         clk;
    logic         RESET;
    logic [N-1:0] IrqIn;
    logic         MaskWE;
    logic [N-1:0] MaskWD;
    logic         pc_31;
    logic         IrqAck;
    logic         Eoi;
    logic         IRQ;
    logic [31:0]  VecAddr;
    logic [2:0]   ActiveId;
    logic         InService;
    logic [N-1:0] Pending;
    logic [N-1:0] Enable;

    vectored_irq_controller #(
        .NUM_IRQ    (N),
        .ADDR_WIDTH (32),
        .VEC_BASE   (32'h80000008),
        .VEC_STRIDE (4),
        .EDGE_MASK  (8'hEF)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .IrqIn     (IrqIn),
        .MaskWE    (MaskWE),
        .MaskWD    (MaskWD),
        .pc_31     (pc_31),
        .IrqAck    (IrqAck),
        .Eoi       (Eoi),
        .IRQ       (IRQ),
        .VecAddr   (VecAddr),
        .ActiveId  (ActiveId),
        .InService (InService),
        .Pending   (Pending),
        .Enable    (Enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each expected IRQ assertion carries the channel and vector.
    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] vec_of(input int id);
        return 32'h80000008 + 32'(4 * id);
    endfunction

    task automatic expect_irq(input int id);
        exp_t e;
        e.id  = 3'(id);
        e.vec = vec_of(id);
        sb.push_back(e);
    endtask

    // Monitor: on every rising IRQ, pop and compare the latched id/vector.
    logic irq_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (IRQ && !irq_prev) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("irq_active_id", 32'(ActiveId), 32'(e.id));
                check_eq("irq_vec_addr", VecAddr, e.vec);
            end
        end
        irq_prev = IRQ;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_enable(input logic [N-1:0] v);
        MaskWE = 1'b1;
        MaskWD = v;
        cyc(1);
        MaskWE = 1'b0;
    endtask

    task automatic ack_cycle();
        IrqAck = 1'b1;
        cyc(1);
        IrqAck = 1'b0;
    endtask

    task automatic eoi_cycle();
        Eoi = 1'b1;
        cyc(1);
        Eoi = 1'b0;
    endtask

    initial begin
        RESET  = 1'b1;
        IrqIn  = '0;
        MaskWE = 1'b0;
        MaskWD = '0;
        pc_31  = 1'b0;
        IrqAck = 1'b0;
        Eoi    = 1'b0;

        // Reset state
        cyc(2);
        check_eq("rst_irq", 32'(IRQ), 32'd0);
        check_eq("rst_insvc", 32'(InService), 32'd0);
        check_eq("rst_pending", 32'(Pending), 32'd0);
        check_eq("rst_enable", 32'(Enable), 32'd0);
        check_eq("rst_vec", VecAddr, 32'h80000008);
        check_eq("rst_id", 32'(ActiveId), 32'd0);
        RESET = 1'b0;
        cyc(1);

        // 1: single edge on channel 3, exact latency
        write_enable(8'hFF);
        check_eq("t1_enable", 32'(Enable), 32'hFF);
        IrqIn = 8'h08;
        expect_irq(3);
        cyc(1);
        IrqIn = '0;
        check_eq("t1_pending", 32'(Pending), 32'h08);
        check_eq("t1_irq_k", 32'(IRQ), 32'd0);
        cyc(1);
        check_eq("t1_irq_k1", 32'(IRQ), 32'd1);
        ack_cycle();
        check_eq("t1_insvc", 32'(InService), 32'd1);
        check_eq("t1_irq_svc", 32'(IRQ), 32'd0);
        check_eq("t1_pend_clr", 32'(Pending), 32'h00);
        eoi_cycle();
        check_eq("t1_insvc_eoi", 32'(InService), 32'd0);
        check_eq("t1_irq_eoi", 32'(IRQ), 32'd0);
        cyc(1);

        // 2: simultaneous 5 and 2, lower index first, then back-to-back
        IrqIn = 8'h24;
        expect_irq(2);
        expect_irq(5);
        cyc(1);
        IrqIn = '0;
        check_eq("t2_pending", 32'(Pending), 32'h24);
        cyc(1);
        check_eq("t2_irq_a", 32'(IRQ), 32'd1);
        ack_cycle();
        check_eq("t2_pend_after_ack", 32'(Pending), 32'h20);
        eoi_cycle();
        check_eq("t2_idle_gap_irq", 32'(IRQ), 32'd0);
        check_eq("t2_idle_gap_svc", 32'(InService), 32'd0);
        cyc(1);
        check_eq("t2_irq_b", 32'(IRQ), 32'd1);
        ack_cycle();
        eoi_cycle();
        check_eq("t2_pend_empty", 32'(Pending), 32'h00);
        cyc(1);

        // 3: masked edge remembered, released by enable write
        write_enable(8'h00);
        IrqIn = 8'h02;
        cyc(1);
        IrqIn = '0;
        cyc(3);
        check_eq("t3_pending", 32'(Pending), 32'h02);
        check_eq("t3_irq_masked", 32'(IRQ), 32'd0);
        expect_irq(1);
        write_enable(8'h02);
        check_eq("t3_irq_same_cyc", 32'(IRQ), 32'd0);
        cyc(1);
        check_eq("t3_irq", 32'(IRQ), 32'd1);
        ack_cycle();
        eoi_cycle();
        write_enable(8'hFF);

        // 4: supervisor suppression, including withdrawal from REQ
        pc_31 = 1'b1;
        IrqIn = 8'h01;
        cyc(1);
        IrqIn = '0;
        cyc(3);
        check_eq("t4_irq_sup", 32'(IRQ), 32'd0);
        check_eq("t4_pending", 32'(Pending), 32'h01);
        expect_irq(0);
        pc_31 = 1'b0;
        cyc(1);
        check_eq("t4_irq_user", 32'(IRQ), 32'd1);
        pc_31 = 1'b1;
        cyc(1);
        check_eq("t4_irq_withdrawn", 32'(IRQ), 32'd0);
        check_eq("t4_pend_kept", 32'(Pending), 32'h01);
        expect_irq(0);
        pc_31 = 1'b0;
        cyc(2);
        check_eq("t4_irq_again", 32'(IRQ), 32'd1);
        ack_cycle();
        eoi_cycle();
        check_eq("t4_pend_empty", 32'(Pending), 32'h00);
        cyc(1);

        // 5: level channel 4 dropped before ack, then held through ack
        IrqIn = 8'h10;
        expect_irq(4);
        cyc(1);
        check_eq("t5_pending_lvl", 32'(Pending), 32'h10);
        cyc(1);
        check_eq("t5_irq", 32'(IRQ), 32'd1);
        IrqIn = '0;
        cyc(1);
        check_eq("t5_pend_drop", 32'(Pending), 32'h00);
        cyc(1);
        check_eq("t5_irq_drop", 32'(IRQ), 32'd0);
        check_eq("t5_no_svc", 32'(InService), 32'd0);
        IrqIn = 8'h10;
        expect_irq(4);
        cyc(2);
        check_eq("t5_irq_hold", 32'(IRQ), 32'd1);
        ack_cycle();
        check_eq("t5_insvc", 32'(InService), 32'd1);
        check_eq("t5_pend_lvl_ack", 32'(Pending[4]), 32'd1);

        // Higher-priority edge during service: remembered, no preemption
        IrqIn = 8'h11;
        cyc(1);
        IrqIn = 8'h10;
        cyc(1);
        check_eq("t5_nopreempt_id", 32'(ActiveId), 32'd4);
        check_eq("t5_nopreempt_vec", VecAddr, 32'h80000018);
        check_eq("t5_pend_edge0", 32'(Pending[0]), 32'd1);

        // 6: async reset mid-service, checked before any clock edge
        IrqIn = '0;
        #2;
        RESET = 1'b1;
        #1;
        check_eq("t6_irq", 32'(IRQ), 32'd0);
        check_eq("t6_insvc", 32'(InService), 32'd0);
        check_eq("t6_pending", 32'(Pending), 32'd0);
        check_eq("t6_enable", 32'(Enable), 32'd0);
        check_eq("t6_vec", VecAddr, 32'h80000008);
        check_eq("t6_id", 32'(ActiveId), 32'd0);
        cyc(2);
        RESET = 1'b0;
        cyc(3);
        check_eq("t6_post_irq", 32'(IRQ), 32'd0);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vectored_irq_controller.md
Name: vectored_irq_controller

Overview:
- Parametrised successor to the core's single-line IRQ path.
- Accepts NUM_IRQ request lines, each configured as edge or level. Holds pending and mask state, and selects the highest-priority unmasked request.
- Drives the control logic's IRQ input with a per-channel vector address, so the fixed XAddr is replaced by VEC_BASE + VEC_STRIDE*id.
- Blocks nesting through an in-service state that is released by end-of-interrupt, and suppresses requests while the core runs in supervisor mode (pc_31=1).

Parameters:
- NUM_IRQ, 8: number of request channels (2..32).
- ADDR_WIDTH, 32: width of the vector address.
- VEC_BASE, 32'h80000008: vector address of channel 0.
- VEC_STRIDE, 4: byte spacing between vectors.
- EDGE_MASK, {NUM_IRQ{1'b1}}: bit i=1 means channel i is rising-edge; bit i=0 means level-high.
- ID_W (localparam), clog2(NUM_IRQ): channel id width.

Ports:
- clk  in  1  global clock.
- RESET  in  1  reset; asynchronous, active-high.
- IrqIn  in  NUM_IRQ  raw request lines, already synchronous to clk.
- MaskWE  in  1  write enable for the enable register.
- MaskWD  in  NUM_IRQ  new enable value; 1 = channel enabled.
- pc_31  in  1  supervisor bit of the current PC; 1 suppresses requests.
- IrqAck  in  1  core is taking the exception this cycle.
- Eoi  in  1  end of interrupt (handler return).
- IRQ  out  1  interrupt request to the control logic.
- VecAddr  out  ADDR_WIDTH  handler address for the latched channel.
- ActiveId  out  ID_W  latched channel id.
- InService  out  1  high while a handler is running.
- Pending  out  NUM_IRQ  registered pending bits.
- Enable  out  NUM_IRQ  current enable register.

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE; Pending, Enable, edge history, ActiveId all 0.
  - IRQ=0, InService=0, VecAddr=VEC_BASE.
- Edge channel i:
  - prev_i is IrqIn_i registered.
  - Pending_i is set on the clk where IrqIn_i=1 and prev_i=0.
  - Pending_i is cleared when the channel is acknowledged.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Pending is not affected by the mask; a masked edge is remembered.
- Level channel i: Pending_i <= IrqIn_i every cycle; IrqAck never clears it.
- Enable: Enable <= MaskWD on clk when MaskWE=1. A write takes effect for arbitration starting the next cycle.
- Arbitration: candidates = Pending & Enable; the lowest index wins; the search is combinational over registered values.
- FSM states:
  - IDLE: if candidates!=0 and pc_31=0, latch winner into ActiveId and go to REQ.
  - REQ:
    - IRQ=1.
    - If pc_31=1, or Enable[ActiveId]=0, or Pending[ActiveId]=0 (level dropped): go to IDLE with no ack.
    - Else if IrqAck=1: go to SERVICE and clear Pending[ActiveId] if the channel is edge.
  - SERVICE: InService=1, IRQ=0; on Eoi=1 go to IDLE.
- Stability: ActiveId and VecAddr are stable for the whole of REQ and SERVICE. A higher-priority arrival does not preempt.
- VecAddr = VEC_BASE + VEC_STRIDE*ActiveId; it is registered and updates in the same cycle ActiveId is latched.
- Ignored inputs: IrqAck outside REQ; Eoi outside SERVICE.
- Latency: IrqIn sampled high at clk k → Pending high after k → REQ/IRQ high after clk k+1. IRQ is therefore first visible 2 clocks after the request is sampled.
- Back-to-back: after Eoi the FSM is in IDLE for 1 cycle, then re-arbitrates; the minimum gap between IRQ pulses is 1 idle cycle.
- Reset mid-operation: everything returns to reset values immediately, and any pending edges are lost.
- All outputs are registered except IRQ and InService, which decode directly from the state register.

Test Plan:
1. Reset, then Enable=8'hFF. Pulse IrqIn[3] (edge) for one cycle → IRQ=1 two clocks later, ActiveId=3, VecAddr=32'h80000014. IrqAck → Pending[3]=0, InService=1. Eoi → IRQ=0, state IDLE.
2. Raise IrqIn[5] and IrqIn[2] in the same cycle, Enable=FF → ActiveId=2, VecAddr=32'h80000010. After ack and Eoi, the next IRQ has ActiveId=5, VecAddr=32'h8000001C, with one idle cycle between the two IRQ pulses.
3. Enable=0, pulse IrqIn[1] → no IRQ, Pending[1]=1. Write Enable=8'h02 → IRQ=1 with ActiveId=1.
4. pc_31=1 with Pending[0]=1, Enable=FF → IRQ stays 0. Drop pc_31 → IRQ=1. Raise pc_31 while in REQ → IRQ=0 next cycle, Pending[0] still 1.
5. EDGE_MASK bit 4=0 (level). Hold IrqIn[4] → IRQ=1. Release IrqIn[4] before ack → returns to IDLE, no service. Hold through ack → Pending[4] remains 1 after ack.
6. Assert RESET asynchronously during SERVICE → IRQ=0, InService=0, Pending=0, Enable=0, VecAddr=32'h80000008 without waiting for clk.
